// File: rtl/tank_motion.sv
// tank_motion: player tank movement with clamped playfield edges and a death/respawn/spawn-shield life cycle.
module tank_motion #(
    parameter int X_CENTER = 160,
    parameter int Y_CENTER = 240,
    parameter int X_MIN = 1,
    parameter int X_MAX = 639,
    parameter int Y_MIN = 1,
    parameter int Y_MAX = 479,
    parameter int SIZE = 4,
    parameter int STEP = 1,
    parameter logic [7:0] KEY_LEFT = 8'h04,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_DOWN = 8'h16,
    parameter logic [7:0] KEY_UP = 8'h1A,
    parameter int NUM_KEYS = 4,
    parameter int RESPAWN_FRAMES = 60,
    parameter int SHIELD_FRAMES = 120,
    parameter logic [1:0] INIT_DIR = 2'b01
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic                  was_hit,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic [9:0]            TankX,
    output logic [9:0]            TankY,
    output logic [9:0]            TankS,
    output logic [1:0]            direction,
    output logic                  moving,
    output logic                  alive,
    output logic                  shielded
);
    localparam int CW = $clog2((RESPAWN_FRAMES > SHIELD_FRAMES ? RESPAWN_FRAMES : SHIELD_FRAMES) + 1);
    localparam logic signed [10:0] ST = 11'(STEP);
    localparam logic signed [10:0] XLO = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] XHI = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] YLO = 11'(Y_MIN + SIZE);
    localparam logic signed [10:0] YHI = 11'(Y_MAX - SIZE);

    typedef enum logic [1:0] {ALIVE, DEAD, SPAWN} state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic found;
    logic [1:0] sel;
    logic [7:0] key;
    logic signed [10:0] xs, ys, xm, xp, ym, yp;
    logic [9:0] nx, ny;

    assign TankS = 10'(SIZE);

    // lowest slot holding a movement key wins
    always_comb begin
        found = 1'b0;
        sel = 2'b00;
        key = 8'h00;
        for (int i = 0; i < NUM_KEYS; i++) begin
            key = keycodes[8*i +: 8];
            if (!found && (key == KEY_LEFT || key == KEY_RIGHT || key == KEY_DOWN || key == KEY_UP)) begin
                found = 1'b1;
                sel = key == KEY_LEFT ? 2'b00 : key == KEY_RIGHT ? 2'b01 : key == KEY_DOWN ? 2'b10 : 2'b11;
            end
        end
    end

    // 11-bit signed candidates so a clamp never sees a wrapped value
    assign xs = signed'({1'b0, TankX});
    assign ys = signed'({1'b0, TankY});
    assign xm = xs - ST;
    assign xp = xs + ST;
    assign ym = ys - ST;
    assign yp = ys + ST;

    always_comb begin
        nx = !found || sel[1] ? TankX : sel[0] ? (xp > XHI ? XHI[9:0] : xp[9:0]) : (xm < XLO ? XLO[9:0] : xm[9:0]);
        ny = !found || !sel[1] ? TankY : sel[0] ? (ym < YLO ? YLO[9:0] : ym[9:0]) : (yp > YHI ? YHI[9:0] : yp[9:0]);
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ALIVE;
            cnt <= '0;
            TankX <= 10'(X_CENTER);
            TankY <= 10'(Y_CENTER);
            direction <= INIT_DIR;
            moving <= 1'b0;
            alive <= 1'b1;
            shielded <= 1'b0;
        end else if (state == DEAD) begin
            moving <= 1'b0;
            if (cnt == '0) begin
                state <= SPAWN;
                cnt <= CW'(SHIELD_FRAMES - 1);
                TankX <= 10'(X_CENTER);
                TankY <= 10'(Y_CENTER);
                direction <= INIT_DIR;
                alive <= 1'b1;
                shielded <= 1'b1;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (state != SPAWN && was_hit) begin
            state <= DEAD;
            cnt <= CW'(RESPAWN_FRAMES - 1);
            moving <= 1'b0;
            alive <= 1'b0;
        end else begin
            TankX <= nx;
            TankY <= ny;
            direction <= found ? sel : direction;
            moving <= {nx, ny} != {TankX, TankY};
            if (state == SPAWN) begin
                if (cnt == '0) begin
                    state <= ALIVE;
                    shielded <= 1'b0;
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tank_motion.sv
// tb_tank_motion: table-driven check of movement, clamping, key priority and the life cycle.
module tb_tank_motion;
    typedef struct packed {
        logic [31:0] keys;
        logic hit;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] dir;
        logic mv;
        logic al;
        logic sh;
    } vec_t;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic rst_m, rst_s, hit_m, hit_s;
    logic [31:0] keys_m, keys_s;
    logic [9:0] x_m, y_m, s_m, x_s, y_s, s_s;
    logic [1:0] dir_m, dir_s;
    logic mv_m, al_m, sh_m, mv_s, al_s, sh_s;
    logic [34:0] out_m, out_s;
    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tm[21];
    vec_t ts[5];

    assign out_m = {x_m, y_m, s_m, dir_m, mv_m, al_m, sh_m};
    assign out_s = {x_s, y_s, s_s, dir_s, mv_s, al_s, sh_s};

    tank_motion #(.RESPAWN_FRAMES(3), .SHIELD_FRAMES(2)) dut_m (
        .frame_clk(frame_clk), .Reset_n(rst_m), .was_hit(hit_m), .keycodes(keys_m),
        .TankX(x_m), .TankY(y_m), .TankS(s_m), .direction(dir_m),
        .moving(mv_m), .alive(al_m), .shielded(sh_m)
    );

    tank_motion #(.X_CENTER(9), .STEP(3)) dut_s (
        .frame_clk(frame_clk), .Reset_n(rst_s), .was_hit(hit_s), .keycodes(keys_s),
        .TankX(x_s), .TankY(y_s), .TankS(s_s), .direction(dir_s),
        .moving(mv_s), .alive(al_s), .shielded(sh_s)
    );

    function automatic vec_t mk(input logic [31:0] k, input logic h, input int x, input int y,
                                input logic [1:0] d, input logic mv, input logic al, input logic sh);
        mk = '{k, h, 10'(x), 10'(y), d, mv, al, sh};
    endfunction

    function automatic logic [34:0] exp_of(input vec_t v);
        exp_of = {v.x, v.y, 10'd4, v.dir, v.mv, v.al, v.sh};
    endfunction

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d s=%0d dir=%b mv=%b al=%b sh=%b, expected x=%0d y=%0d s=%0d dir=%b mv=%b al=%b sh=%b",
                     name, got[34:25], got[24:15], got[14:5], got[4:3], got[2], got[1], got[0],
                     exp[34:25], exp[24:15], exp[14:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input string tag, input int i, input bit s, input vec_t v);
        vec_t e;
        if (s) begin
            keys_s = v.keys;
            hit_s = v.hit;
        end else begin
            keys_m = v.keys;
            hit_m = v.hit;
        end
        sb.push_back(v);
        @(posedge frame_clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: scoreboard empty", tag, i);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s[%0d]", tag, i), s ? out_s : out_m, exp_of(e));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 10; i++) tm[i] = mk(32'h07, 0, 161 + i, 240, 2'b01, 1, 1, 0);
        tm[10] = mk(32'h00041A2C, 0, 170, 239, 2'b11, 1, 1, 0);
        tm[11] = mk(32'h16, 0, 170, 240, 2'b10, 1, 1, 0);
        for (int i = 12; i < 15; i++) tm[i] = mk(32'h00, 1, 170, 240, 2'b10, 0, 0, 0);
        tm[15] = mk(32'h00, 1, 160, 240, 2'b01, 0, 1, 1);
        tm[16] = mk(32'h07, 1, 161, 240, 2'b01, 1, 1, 1);
        tm[17] = mk(32'h00, 0, 161, 240, 2'b01, 0, 1, 0);
        tm[18] = mk(32'h07, 1, 161, 240, 2'b01, 0, 0, 0);
        tm[19] = mk(32'h07, 0, 161, 240, 2'b01, 0, 0, 0);
        tm[20] = mk(32'h07, 0, 161, 240, 2'b01, 1, 1, 0);
        ts[0] = mk(32'h04, 0, 6, 240, 2'b00, 1, 1, 0);
        ts[1] = mk(32'h04, 0, 5, 240, 2'b00, 1, 1, 0);
        ts[2] = mk(32'h04, 0, 5, 240, 2'b00, 0, 1, 0);
        ts[3] = mk(32'h1A, 0, 5, 237, 2'b11, 1, 1, 0);
        ts[4] = mk(32'h07, 0, 8, 237, 2'b01, 1, 1, 0);

        rst_m = 1'b0;
        rst_s = 1'b0;
        hit_m = 1'b0;
        hit_s = 1'b0;
        keys_m = '0;
        keys_s = '0;
        repeat (2) @(posedge frame_clk);
        #1;
        check("reset_m", out_m, {10'd160, 10'd240, 10'd4, 2'b01, 3'b010});
        check("reset_s", out_s, {10'd9, 10'd240, 10'd4, 2'b01, 3'b010});
        rst_m = 1'b1;
        rst_s = 1'b1;

        for (int i = 0; i < 5; i++) apply("step3", i, 1'b1, ts[i]);
        for (int i = 0; i < 20; i++) apply("main", i, 1'b0, tm[i]);

        // asynchronous reset between edges while DEAD
        #3;
        rst_m = 1'b0;
        #1;
        check("async_reset_dead", out_m, {10'd160, 10'd240, 10'd4, 2'b01, 3'b010});
        #1;
        rst_m = 1'b1;
        apply("main", 20, 1'b0, tm[20]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tank_motion.md
# tank_motion

Parametrised player-tank motion and life controller; the next generation of the Player 1 tank block. It runs on the frame clock, scans several simultaneous keycodes for configurable movement keys, and moves the tank with clamped, overshoot-free boundary handling. It also manages a death / respawn / spawn-shield life cycle. Outputs feed the sprite renderer, projectile spawner and collision logic. One instance per player, differing only in parameters.

## Interface
- X_CENTER, 160, respawn X position
- Y_CENTER, 240, respawn Y position
- X_MIN / X_MAX, 1 / 639, horizontal playfield limits
- Y_MIN / Y_MAX, 1 / 479, vertical playfield limits
- SIZE, 4, tank half-size; the tank edge is the centre ± SIZE
- STEP, 1, pixels moved per frame (1..15)
- KEY_LEFT / KEY_RIGHT / KEY_DOWN / KEY_UP, 8'h04 / 8'h07 / 8'h16 / 8'h1A, USB HID movement keycodes
- NUM_KEYS, 4, keycode slots scanned (1..6)
- RESPAWN_FRAMES, 60, frames spent dead (≥1)
- SHIELD_FRAMES, 120, frames of post-spawn invulnerability (≥1)
- INIT_DIR, 2'b01, facing at reset/respawn: 00 left, 01 right, 10 down, 11 up

Ports (name, direction, width, meaning):
- frame_clk  in  1  frame clock, the single clock domain
- Reset_n  in  1  asynchronous, active-low reset
- was_hit  in  1  hit pulse, sampled synchronously on frame_clk
- keycodes  in  8*NUM_KEYS  slot i occupies bits [8i+7:8i]
- TankX, TankY  out  10  tank centre position
- TankS  out  10  constant SIZE
- direction  out  2  current facing, same encoding as INIT_DIR
- moving  out  1  position changed on the last edge
- alive  out  1  tank is present on the playfield
- shielded  out  1  hits are currently ignored

## Operation
- States: ALIVE, DEAD, SPAWN. A down-counter sized $clog2(max(RESPAWN_FRAMES, SHIELD_FRAMES)+1) bits times DEAD and SPAWN.
- Key decode: scan slots from index 0 upward.
  - The first slot equal to any movement key selects the move.
  - Slots holding other or zero keycodes are skipped.
  - No match means no move.
- Move, in ALIVE and SPAWN only:
  - Set direction to the selected key's facing, even when the move is blocked.
  - Compute the candidate position in 11-bit signed arithmetic. No 10-bit wrap is permitted.
  - Left: X = max(X − STEP, X_MIN + SIZE). Right: X = min(X + STEP, X_MAX − SIZE).
  - Up: Y = max(Y − STEP, Y_MIN + SIZE). Down: Y = min(Y + STEP, Y_MAX − SIZE).
  - Only one axis changes per frame.
  - moving = 1 iff the new position differs from the old one.
- ALIVE:
  - If was_hit = 1, enter DEAD and load the counter with RESPAWN_FRAMES−1.
  - On that edge there is no movement; the hit wins over the key.
- DEAD:
  - alive = 0, moving = 0.
  - Position and direction are frozen; keys and was_hit are ignored.
  - If the counter is 0, enter SPAWN. Otherwise decrement.
- Entry to SPAWN:
  - TankX = X_CENTER, TankY = Y_CENTER, direction = INIT_DIR.
  - Load the counter with SHIELD_FRAMES−1.
  - There is no movement on the entry edge.
- SPAWN:
  - alive = 1, shielded = 1.
  - Movement works as in ALIVE; was_hit is ignored.
  - If the counter is 0, enter ALIVE. Otherwise decrement.
- The ALIVE/SPAWN/DEAD → next-state edge applies that edge's move per the current state's rules.

## Timing
- All outputs are registered. A key present before edge k is reflected in position after edge k (1-frame latency). There is no extra motion-register stage.
- was_hit high at edge k gives alive = 0 after edge k.
- DEAD lasts exactly RESPAWN_FRAMES frames. After edge k+RESPAWN_FRAMES: alive = 1, shielded = 1, position at centre.
- shielded falls after edge k+RESPAWN_FRAMES+SHIELD_FRAMES.
- Reset_n low, asynchronously and at any time including mid-DEAD or mid-SPAWN, forces:
  - state ALIVE, counter 0;
  - TankX = X_CENTER, TankY = Y_CENTER, direction = INIT_DIR;
  - moving = 0, alive = 1, shielded = 0.
- After release, the first active edge behaves normally.
- A multi-frame was_hit level counts only once, since DEAD and SPAWN ignore it.

## Test plan
- Reset, then keycodes = {00,00,00,07} for 5 frames -> TankX = 165, TankY = 240, direction = 01, moving = 1 each frame.
- STEP = 3, position X = 9, hold 04 -> X = 6, then 5, then held at 5; moving goes 1, 1, 0; direction = 00 throughout.
- keycodes slot0 = 2C, slot1 = 1A, slot2 = 04 -> only Y decrements, direction = 11 (slot 1 wins over slot 2).
- RESPAWN_FRAMES = 3, SHIELD_FRAMES = 2:
  - Move to (170, 240), pulse was_hit for 4 frames.
  - Expect alive = 0 for 3 frames with position frozen at (170, 240).
  - Then (160, 240) with alive = 1 and shielded = 1 for 2 frames; the repeated hits have no effect.
  - Then shielded = 0.
- was_hit and key 07 asserted on the same ALIVE edge -> position is unchanged and alive = 0.
- Assert Reset_n low mid-DEAD, between edges -> outputs immediately read (160, 240), alive = 1, shielded = 0, direction = 01.
